// File: rtl/uart_pkg.sv
// Shared types, line levels and helpers for the UART transmitter and the
// planned receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam int   UART_MAX_BITS  = 9;

  // Unused upper bits are expected to be zero so they do not disturb the XOR.
  function automatic logic parity_calc(input logic [UART_MAX_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Rising-edge detector on the divider's baud_clk; one CLK100MHZ-cycle tick
// per baud period. baud_clk already lives in this domain, so no synchroniser.
module uart_tick_gen (
  input  logic CLK100MHZ,
  input  logic resetn,
  input  logic baud_clk,
  output logic tick
);

  logic baud_q_reg;

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      baud_q_reg <= 1'b0;
    end else begin
      baud_q_reg <= baud_clk;
    end
  end

  assign tick = baud_clk & ~baud_q_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, framed as start,
// data LSB first, optional parity and 1..2 stop bits, one bit per baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK100MHZ,
  input  logic                 resetn,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [3:0] DATA_CNT = 4'(DATA_BITS);
  localparam logic [3:0] STOP_CNT = 4'(STOP_BITS);

  tx_state_t            state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 tick;
  logic                 accept;
  logic [UART_MAX_BITS-1:0] data_pad;

  uart_tick_gen u_tick (
    .CLK100MHZ (CLK100MHZ),
    .resetn    (resetn),
    .baud_clk  (baud_clk),
    .tick      (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < UART_MAX_BITS; gi++) begin : g_pad
      if (gi < DATA_BITS) begin : g_bit
        assign data_pad[gi] = tx_data[gi];
      end else begin : g_zero
        assign data_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign accept = tx_valid & tx_ready;

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= UART_IDLE_LVL;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // Apart from the accept, every move waits for a tick, so a stalled baud_clk freezes the frame.
  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = UART_IDLE_LVL;
        if (accept) begin
          shift_next  = tx_data;
          parity_next = parity_calc(data_pad, 1'(PARITY_ODD));
          cnt_next    = '0;
          busy_next   = 1'b1;
          state_next  = ALIGN;
        end
      end
      ALIGN: if (tick) begin
        tx_next    = UART_START_LVL;
        state_next = START;
      end
      START: if (tick) begin
        tx_next    = shift_reg[0];
        shift_next = shift_reg >> 1;
        cnt_next   = 4'd1;
        state_next = DATA;
      end
      DATA: if (tick) begin
        if (cnt_reg < DATA_CNT) begin
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          cnt_next   = cnt_reg + 4'd1;
        end else if (PARITY_EN != 0) begin
          tx_next    = parity_reg;
          state_next = PARITY;
        end else begin
          tx_next    = UART_IDLE_LVL;
          cnt_next   = 4'd1;
          state_next = STOP;
        end
      end
      PARITY: if (tick) begin
        tx_next    = UART_IDLE_LVL;
        cnt_next   = 4'd1;
        state_next = STOP;
      end
      STOP: if (tick) begin
        if (cnt_reg == STOP_CNT) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state_reg == IDLE);
    tx       = tx_reg;
    tx_busy  = busy_reg;
    tx_done  = done_reg;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven from one baud source with
// count_lim=4, frames compared against an arithmetic frame model.
module tb_uart_tx;

  localparam int CFG_DB [4] = '{8, 8, 8, 5};
  localparam int CFG_PE [4] = '{0, 1, 1, 0};
  localparam int CFG_PO [4] = '{0, 0, 1, 0};
  localparam int CFG_SB [4] = '{1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       baud_clk = 1'b0;
  logic       baud_run = 1'b1;
  int         bcnt = 0;
  logic [8:0] tx_data_w = '0;
  logic [3:0] tx_valid_w = '0;
  logic [3:0] tx_ready_w, tx_w, tx_busy_w, tx_done_w;
  int         tests_run = 0;
  int         tests_failed = 0;

  typedef struct {
    int         cfg;
    logic [8:0] data;
    int         len;
    logic [11:0] frame;
  } vec_t;

  always #5 clk = ~clk;

  // Divider model: baud_clk toggles every 4 cycles, freezes while baud_run=0.
  always @(negedge clk) begin
    if (baud_run) begin
      if (bcnt == 3) begin
        bcnt = 0;
        baud_clk = ~baud_clk;
      end else begin
        bcnt++;
      end
    end
  end

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .CLK100MHZ(clk), .resetn(resetn), .baud_clk(baud_clk), .tx_data(tx_data_w[7:0]),
    .tx_valid(tx_valid_w[0]), .tx_ready(tx_ready_w[0]), .tx(tx_w[0]),
    .tx_busy(tx_busy_w[0]), .tx_done(tx_done_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .CLK100MHZ(clk), .resetn(resetn), .baud_clk(baud_clk), .tx_data(tx_data_w[7:0]),
    .tx_valid(tx_valid_w[1]), .tx_ready(tx_ready_w[1]), .tx(tx_w[1]),
    .tx_busy(tx_busy_w[1]), .tx_done(tx_done_w[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .CLK100MHZ(clk), .resetn(resetn), .baud_clk(baud_clk), .tx_data(tx_data_w[7:0]),
    .tx_valid(tx_valid_w[2]), .tx_ready(tx_ready_w[2]), .tx(tx_w[2]),
    .tx_busy(tx_busy_w[2]), .tx_done(tx_done_w[2]));
  uart_tx #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .CLK100MHZ(clk), .resetn(resetn), .baud_clk(baud_clk), .tx_data(tx_data_w[4:0]),
    .tx_valid(tx_valid_w[3]), .tx_ready(tx_ready_w[3]), .tx(tx_w[3]),
    .tx_busy(tx_busy_w[3]), .tx_done(tx_done_w[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame as transmitted, bit i = i-th bit on the line.
  function automatic void model_frame(input int cfg, input logic [8:0] d,
                                      output int len, output logic [11:0] f);
    int pos;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < CFG_DB[cfg]; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    pos = 1 + CFG_DB[cfg];
    if (CFG_PE[cfg] != 0) begin
      f[pos] = ((ones % 2) == 1) ^ (CFG_PO[cfg] != 0);
      pos++;
    end
    len = pos + CFG_SB[cfg];
  endfunction

  task automatic send_frame(input int idx, input logic [8:0] data, input int len,
                            input logic [11:0] exp, input int stall_k, input string name);
    int n;
    int r;
    int lat_exp;
    int bad;
    int sbad;
    logic [11:0] obs;
    logic [11:0] mask;
    n = 0;
    while (tx_ready_w[idx] !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "/ready"}, 32'(tx_ready_w[idx]), 32'd1);
    // Negedge index of the next baud_clk rise, seen from the driving point.
    r = baud_clk ? 8 - bcnt : 4 - bcnt;
    lat_exp = (r == 1) ? 8 : r - 1;
    tx_data_w = data;
    tx_valid_w[idx] = 1'b1;
    @(posedge clk); #1;
    tx_valid_w[idx] = 1'b0;
    tx_data_w = ~data;
    check({name, "/busy_ready_after_accept"}, 32'({tx_busy_w[idx], tx_ready_w[idx]}), 32'b10);
    n = 0;
    while (tx_w[idx] !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "/start_latency"}, n, lat_exp);
    bad = 0;
    sbad = 0;
    obs = '1;
    for (int k = 0; k < len * 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k % 8 == 4) obs[k/8] = tx_w[idx];
      if (tx_w[idx] !== exp[k/8] || tx_ready_w[idx] !== 1'b0 ||
          tx_busy_w[idx] !== 1'b1 || tx_done_w[idx] !== 1'b0) bad++;
      if (k == stall_k) begin
        baud_run = 1'b0;
        repeat (100) begin
          @(posedge clk); #1;
          if (tx_w[idx] !== exp[k/8] || tx_busy_w[idx] !== 1'b1 || tx_done_w[idx] !== 1'b0) sbad++;
        end
        baud_run = 1'b1;
      end
    end
    @(posedge clk); #1;
    check({name, "/done_busy_ready_tx"},
          32'({tx_done_w[idx], tx_busy_w[idx], tx_ready_w[idx], tx_w[idx]}), 32'b1011);
    @(posedge clk); #1;
    check({name, "/done_one_cycle"}, 32'(tx_done_w[idx]), 32'd0);
    mask = '0;
    for (int i = 0; i < len; i++) mask[i] = 1'b1;
    check({name, "/frame_bits"}, 32'(obs & mask), 32'(exp & mask));
    check({name, "/bit_timing_errors"}, bad, 0);
    if (stall_k >= 0) check({name, "/stall_hold_errors"}, sbad, 0);
    $display("[TB] %s cfg%0d data=0x%03h frame=0x%03h len=%0d latency=%0d",
             name, idx, data, obs & mask, len, n);
  endtask

  initial begin
    vec_t vecs [7];
    int n;
    int len;
    logic [11:0] f;
    int cfg;
    logic [8:0] d;
    int start1, start2, stop1, done1, acc2, ndone, nstart;
    logic prev_tx;
    logic first_acc;
    logic [11:0] frame2;

    vecs[0] = '{0, 9'h0A5, 10, 12'h34A};
    vecs[1] = '{1, 9'h007, 11, 12'h60E};
    vecs[2] = '{2, 9'h007, 12, 12'hC0E};
    vecs[3] = '{3, 9'h015, 8,  12'h0EA};
    vecs[4] = '{0, 9'h03C, 10, 12'h278};
    vecs[5] = '{1, 9'h000, 11, 12'h400};
    vecs[6] = '{2, 9'h0FF, 12, 12'hFFE};

    // Reset state, both during and after reset
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("reset/during", 32'({tx_w, tx_ready_w, tx_busy_w, tx_done_w}), 32'hFF00);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("reset/after", 32'({tx_w, tx_ready_w, tx_busy_w, tx_done_w}), 32'hFF00);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].cfg, vecs[i].data, vecs[i].len, vecs[i].frame, -1, $sformatf("vec%0d", i));
    end

    // Accept in the very cycle a tick arrives: that tick must not be used
    n = 0;
    while (!(baud_clk == 1'b0 && bcnt == 3) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    send_frame(0, 9'h0C3, 10, 12'h386, -1, "coincident_tick");

    // Baud stalled for 100 cycles in the middle of the data bits
    send_frame(0, 9'h0A5, 10, 12'h34A, 28, "stall");

    // Back-to-back with tx_valid held, then ignored pulses while busy
    start1 = -1; start2 = -1; stop1 = -1; done1 = -1; acc2 = -1;
    ndone = 0; nstart = 0; prev_tx = 1'b1; first_acc = 1'b0; frame2 = '1;
    tx_data_w = 9'h000;
    tx_valid_w[0] = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!first_acc && !tx_ready_w[0]) begin
        first_acc = 1'b1;
        tx_data_w = 9'h0FF;
      end
      if (prev_tx && !tx_w[0]) begin
        nstart++;
        if (start1 < 0) start1 = c;
        else if (start2 < 0) start2 = c;
      end
      if (start1 >= 0 && stop1 < 0 && tx_w[0]) stop1 = c;
      if (tx_done_w[0]) begin
        ndone++;
        if (done1 < 0) done1 = c;
      end
      if (done1 >= 0 && acc2 < 0 && c > done1 && !tx_ready_w[0]) begin
        acc2 = c;
        tx_data_w = 9'h055;
      end
      if (start2 >= 0 && c - start2 < 80 && (c - start2) % 8 == 4) frame2[(c-start2)/8] = tx_w[0];
      if (acc2 >= 0) tx_valid_w[0] = (c - acc2 < 50) && ((c - acc2) % 10 == 5);
      prev_tx = tx_w[0];
    end
    tx_valid_w[0] = 1'b0;
    check("b2b/done_after_start", done1 - start1, 80);
    check("b2b/accept_after_done", acc2 - done1, 1);
    check("b2b/stop_to_next_start", start2 - stop1, 16);
    check("b2b/frame2_bits", 32'(frame2[9:0]), 32'h3FE);
    check("b2b/done_count", ndone, 2);
    check("b2b/start_count", nstart, 2);
    $display("[TB] b2b cfg0 frame1 start=%0d done=%0d accept2=%0d start2=%0d frame2=0x%03h",
             start1, done1, acc2, start2, frame2[9:0]);

    // Reset during data bit 3 of a 0x00 frame
    tx_data_w = 9'h000;
    tx_valid_w[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid_w[0] = 1'b0;
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (34) begin
      @(posedge clk); #1;
    end
    check("rst_mid/tx_low_before", 32'(tx_w[0]), 32'd0);
    resetn = 1'b0;
    #1;
    check("rst_mid/async", 32'({tx_w[0], tx_ready_w[0], tx_busy_w[0], tx_done_w[0]}), 32'b1100);
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    resetn = 1'b1;
    ndone = 0;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (tx_done_w[0]) ndone++;
      if (!tx_w[0] || !tx_ready_w[0]) n++;
    end
    check("rst_mid/no_done", ndone, 0);
    check("rst_mid/idle_after", n, 0);
    $display("[TB] rst_mid cfg0 aborted frame, idle after release");
    send_frame(0, 9'h03C, 10, 12'h278, -1, "rst_recover");

    // Randomised frames against the model
    for (int i = 0; i < 16; i++) begin
      cfg = int'($urandom_range(0, 3));
      d = 9'($urandom);
      model_frame(cfg, d, len, f);
      send_frame(cfg, d, len, f, -1, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
